// File: rtl/rangefinder_sample_capture.sv
// Rangefinder sample capture: arms on CSR write, starts on trigger edge,
// decimates ADC samples and streams them into an external sample RAM.
module rangefinder_sample_capture #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              trig_in,
  input  logic [1:0]        ctrl_address,
  input  logic              ctrl_chipselect,
  input  logic              ctrl_write,
  input  logic              ctrl_read,
  input  logic [15:0]       ctrl_writedata,
  output logic [15:0]       ctrl_readdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              irq
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  state_t             state;
  logic               trig_q;
  logic               irq_en;
  logic               done;
  logic [ADDR_W-1:0]  length;
  logic [7:0]         decim;
  logic [CNT_W-1:0]   count;
  logic [ADDR_W-1:0]  ptr;
  logic [7:0]         dec_cnt;

  logic               csr_wr;
  logic               wr_ctrl;
  logic               wr_status;
  logic               wr_length;
  logic               wr_decim;
  logic               arm_req;
  logic               abort_req;
  logic               trig_edge;
  logic               busy;
  logic [CNT_W-1:0]   target;
  logic               room;
  logic               advance;
  logic               accept;
  logic               unused_wdata;

  assign csr_wr    = ctrl_chipselect & ctrl_write;
  assign wr_ctrl   = csr_wr & (ctrl_address == 2'd0);
  assign wr_status = csr_wr & (ctrl_address == 2'd1);
  assign wr_length = csr_wr & (ctrl_address == 2'd2);
  assign wr_decim  = csr_wr & (ctrl_address == 2'd3);

  // ABORT dominates when both command bits are written together
  assign abort_req = wr_ctrl & ctrl_writedata[1];
  assign arm_req   = wr_ctrl & ctrl_writedata[0] & ~ctrl_writedata[1];

  assign trig_edge = trig_in & ~trig_q;
  assign busy      = (state != IDLE);

  // LENGTH of zero selects the full RAM depth
  assign target = (length == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                 : {1'b0, length};

  // count already includes the write in flight, so no sample
  // past the last one can be accepted and the pointer never wraps
  assign room    = (count != target);
  assign advance = (state == CAPTURE) & adc_valid & room;
  assign accept  = advance & (dec_cnt == decim);

  assign irq = done & irq_en;

  assign unused_wdata = ^ctrl_writedata;

  // Trigger history for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_in;
    end
  end

  // Software-owned configuration, frozen while a capture is in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      length <= '0;
      decim  <= '0;
    end else begin
      if (wr_ctrl) begin
        irq_en <= ctrl_writedata[2];
      end
      if (wr_length && !busy) begin
        length <= ctrl_writedata[ADDR_W-1:0];
      end
      if (wr_decim && !busy) begin
        decim <= ctrl_writedata[7:0];
      end
    end
  end

  // Capture FSM with its pointer, counters and DONE flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      done    <= 1'b0;
      count   <= '0;
      ptr     <= '0;
      dec_cnt <= '0;
    end else begin
      if (wr_status && ctrl_writedata[1]) begin
        done <= 1'b0;
      end

      if (advance) begin
        if (accept) begin
          dec_cnt <= '0;
        end else begin
          dec_cnt <= dec_cnt + 8'd1;
        end
      end

      if (accept) begin
        ptr   <= ptr + ADDR_W'(1);
        count <= count + CNT_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (arm_req) begin
            state   <= ARMED;
            done    <= 1'b0;
            count   <= '0;
            ptr     <= '0;
            dec_cnt <= '0;
          end
        end
        ARMED: begin
          if (abort_req) begin
            state <= IDLE;
          end else if (trig_edge) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (abort_req) begin
            state <= IDLE;
          end else if (!room) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM write port: one-cycle strobe following each accepted sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_write      <= 1'b0;
      ram_chipselect <= 1'b0;
      ram_address    <= '0;
      ram_writedata  <= '0;
    end else begin
      ram_write      <= accept;
      ram_chipselect <= accept;
      if (accept) begin
        ram_address   <= ptr;
        ram_writedata <= adc_data;
      end
    end
  end

  // Zero-latency CSR read mux
  always_comb begin
    ctrl_readdata = '0;
    if (reset_n && ctrl_chipselect && ctrl_read) begin
      unique case (ctrl_address)
        2'd0: begin
          ctrl_readdata[2] = irq_en;
        end
        2'd1: begin
          ctrl_readdata[0]    = busy;
          ctrl_readdata[1]    = done;
          ctrl_readdata[2]    = (state == ARMED);
          ctrl_readdata[12:4] = 9'(count);
        end
        2'd2: begin
          ctrl_readdata[ADDR_W-1:0] = length;
        end
        2'd3: begin
          ctrl_readdata[7:0] = decim;
        end
        default: begin
          ctrl_readdata = '0;
        end
      endcase
    end
  end

endmodule
